dd_seq_ctrl: RTL and testbench

Sequential binary-to-BCD conversion controller. It accepts a binary operand through a start/ready handshake and runs the double-dabble algorithm one iteration per clock, using a single shared adjust-and-shift stage instead of a fully unrolled combinational chain. It reports completion with a one-cycle done pulse and holds the registered BCD result. It sits between the value producers (counters, sensors) and the decimal display drivers, where area matters more than single-cycle latency.

---
 rtl/dd_seq_ctrl_if.sv | 24 ++
 rtl/dd_seq_ctrl.sv | 112 +++++++++++
 tb/tb_dd_seq_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/dd_seq_ctrl_if.sv
// Handshake and result bus for the sequential binary-to-BCD converter.
// The producer side (master) drives start/bin; the converter (slave)
// reports ready/busy/done and the held BCD result.
interface dd_seq_ctrl_if #(
    parameter int BIN_LEN = 8,
    parameter int BCD_LEN = 12
);
    logic               start;
    logic [BIN_LEN-1:0] bin;
    logic               ready;
    logic               busy;
    logic               done;
    logic [BCD_LEN-1:0] bcd;

    modport master (
        output start, bin,
        input  ready, busy, done, bcd
    );

    modport slave (
        input  start, bin,
        output ready, busy, done, bcd
    );
endinterface

// File: rtl/dd_seq_ctrl.sv
// Sequential double-dabble converter: one shared adjust-and-shift stage
// is reused for BIN_LEN cycles instead of unrolling the whole chain.
// The BCD result is registered and held until the next done pulse.
module dd_seq_ctrl #(
    parameter int BIN_LEN = 8,
    parameter int BCD_LEN = 12
) (
    input  logic         clk,
    input  logic         rst,
    dd_seq_ctrl_if.slave bus
);
    localparam int W_LEN  = BCD_LEN + BIN_LEN;
    localparam int DIGITS = BCD_LEN / 4;
    localparam int CNT_W  = $clog2(BIN_LEN + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [W_LEN-1:0]   work;
    logic [W_LEN-1:0]   adjusted;
    logic [W_LEN-1:0]   shifted;
    logic [CNT_W-1:0]   cnt;
    logic [BCD_LEN-1:0] bcd_q;
    logic               last_iter;
    logic               ready_d;
    logic               busy_d;
    logic               done_d;

    assign last_iter = (cnt == CNT_W'(1));

    // Adjust step: every BCD digit >= 5 gets +3 inside its own nibble,
    // so the following shift carries it into the next digit correctly.
    always_comb begin
        adjusted = work;
        for (int i = 0; i < DIGITS; i++) begin
            if (work[BIN_LEN + 4*i +: 4] >= 4'd5) begin
                adjusted[BIN_LEN + 4*i +: 4] = work[BIN_LEN + 4*i +: 4] + 4'd3;
            end
        end
    end

    assign shifted = {adjusted[W_LEN-2:0], 1'b0};

    // State register; reset aborts any conversion in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and status decode; status depends only on the registered state.
    always_comb begin
        state_next = state;
        ready_d    = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        case (state)
            IDLE: begin
                ready_d = 1'b1;
                if (bus.start) begin
                    state_next = CONV;
                end
            end
            CONV: begin
                busy_d = 1'b1;
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy_d     = 1'b1;
                done_d     = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: load operand on acceptance, iterate in CONV, publish on the last pass.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work  <= '0;
            cnt   <= '0;
            bcd_q <= '0;
        end else begin
            if (state == IDLE && bus.start) begin
                work <= {{BCD_LEN{1'b0}}, bus.bin};
                cnt  <= CNT_W'(BIN_LEN);
            end else if (state == CONV) begin
                work <= shifted;
                cnt  <= cnt - CNT_W'(1);
                if (last_iter) begin
                    bcd_q <= shifted[W_LEN-1 -: BCD_LEN];
                end
            end
        end
    end

    assign bus.ready = ready_d;
    assign bus.busy  = busy_d;
    assign bus.done  = done_d;
    assign bus.bcd   = bcd_q;
endmodule

// File: tb/tb_dd_seq_ctrl.sv
// Directed bench for dd_seq_ctrl: a default 8->12 instance plus an
// undersized 8->8 instance and a minimal 1->4 instance.
module tb_dd_seq_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dd_seq_ctrl_if #(.BIN_LEN(8), .BCD_LEN(12)) bus_a ();
    dd_seq_ctrl_if #(.BIN_LEN(8), .BCD_LEN(8))  bus_b ();
    dd_seq_ctrl_if #(.BIN_LEN(1), .BCD_LEN(4))  bus_c ();

    dd_seq_ctrl #(.BIN_LEN(8), .BCD_LEN(12)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    dd_seq_ctrl #(.BIN_LEN(8), .BCD_LEN(8))  dut_b (.clk(clk), .rst(rst), .bus(bus_b));
    dd_seq_ctrl #(.BIN_LEN(1), .BCD_LEN(4))  dut_c (.clk(clk), .rst(rst), .bus(bus_c));

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setInputs(input int sel, input logic s, input logic [7:0] v);
        case (sel)
            0: begin bus_a.start = s; bus_a.bin = v; end
            1: begin bus_b.start = s; bus_b.bin = v; end
            default: begin bus_c.start = s; bus_c.bin = v[0]; end
        endcase
    endtask

    function automatic logic getDone(input int sel);
        case (sel)
            0:       return bus_a.done;
            1:       return bus_b.done;
            default: return bus_c.done;
        endcase
    endfunction

    function automatic logic getReady(input int sel);
        case (sel)
            0:       return bus_a.ready;
            1:       return bus_b.ready;
            default: return bus_c.ready;
        endcase
    endfunction

    function automatic logic [11:0] getBcd(input int sel);
        case (sel)
            0:       return bus_a.bcd;
            1:       return {4'h0, bus_b.bcd};
            default: return {8'h00, bus_c.bcd};
        endcase
    endfunction

    // Decimal reference for the streaming sweep.
    function automatic logic [11:0] toBcd(input int v);
        return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // One full conversion: accept, wait for done, check latency, result and pulse width.
    task automatic applyStimulus(input int sel, input logic [7:0] value,
                                 input logic [11:0] expected, input int latency,
                                 input string tag);
        int n;
        checkOutput({tag, "_ready_before"}, 32'(getReady(sel)), 32'd1);
        setInputs(sel, 1'b1, value);
        tick();
        setInputs(sel, 1'b0, value);
        n = 0;
        while (!getDone(sel) && n < 40) begin
            tick();
            n++;
        end
        checkOutput({tag, "_latency"}, 32'(n), 32'(latency));
        checkOutput({tag, "_bcd"}, 32'(getBcd(sel)), 32'(expected));
        tick();
        checkOutput({tag, "_done_width"}, 32'(getDone(sel)), 32'd0);
        checkOutput({tag, "_ready_after"}, 32'(getReady(sel)), 32'd1);
        checkOutput({tag, "_bcd_held"}, 32'(getBcd(sel)), 32'(expected));
    endtask

    initial begin
        int n;
        int dones;
        logic [11:0] seen;

        rst = 1'b1;
        setInputs(0, 1'b0, 8'd0);
        setInputs(1, 1'b0, 8'd0);
        setInputs(2, 1'b0, 8'd0);
        #23;
        checkOutput("rst_ready", 32'(bus_a.ready), 32'd1);
        checkOutput("rst_busy",  32'(bus_a.busy),  32'd0);
        checkOutput("rst_done",  32'(bus_a.done),  32'd0);
        checkOutput("rst_bcd",   32'(bus_a.bcd),   32'd0);
        rst = 1'b0;
        tick();

        applyStimulus(0, 8'd255, 12'h255, 8, "a255");
        applyStimulus(0, 8'd0,   12'h000, 8, "a0");
        applyStimulus(0, 8'd9,   12'h009, 8, "a9");
        applyStimulus(0, 8'd100, 12'h100, 8, "a100");
        applyStimulus(0, 8'd58,  12'h058, 8, "a58");

        // Streaming sweep with start held high. ready only rises after DONE
        // returns to IDLE, so each new operand is taken one cycle after that.
        setInputs(0, 1'b1, 8'd0);
        for (int v = 0; v < 256; v++) begin
            n = 0;
            do begin
                tick();
                n++;
            end while (!bus_a.done && n < 40);
            checkOutput($sformatf("stream_bcd_%0d", v), 32'(bus_a.bcd), 32'(toBcd(v)));
            checkOutput($sformatf("stream_gap_%0d", v), 32'(n), (v == 0) ? 32'd9 : 32'd10);
            setInputs(0, 1'b1, 8'(v + 1));
        end
        setInputs(0, 1'b0, 8'd0);
        tick();
        tick();
        checkOutput("stream_idle_ready", 32'(bus_a.ready), 32'd1);

        // Operand and start disturbed while busy: one done, original value.
        setInputs(0, 1'b1, 8'd37);
        tick();
        setInputs(0, 1'b0, 8'd37);
        dones = 0;
        seen  = 12'h000;
        for (int i = 1; i <= 20; i++) begin
            if (i == 3) setInputs(0, 1'b1, 8'd99);
            if (i == 6) setInputs(0, 1'b0, 8'd99);
            tick();
            if (bus_a.done) begin
                dones++;
                seen = bus_a.bcd;
            end
        end
        checkOutput("busy_ignore_dones", 32'(dones), 32'd1);
        checkOutput("busy_ignore_bcd",   32'(seen),  32'h037);

        // Asynchronous reset during the 4th CONV cycle of 200.
        setInputs(0, 1'b1, 8'd200);
        tick();
        setInputs(0, 1'b0, 8'd200);
        tick();
        tick();
        tick();
        checkOutput("abort_busy_before", 32'(bus_a.busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        checkOutput("abort_bcd",   32'(bus_a.bcd),   32'd0);
        checkOutput("abort_ready", 32'(bus_a.ready), 32'd1);
        checkOutput("abort_busy",  32'(bus_a.busy),  32'd0);
        checkOutput("abort_done",  32'(bus_a.done),  32'd0);
        #3 rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (bus_a.done) dones++;
        end
        checkOutput("abort_no_done", 32'(dones), 32'd0);
        applyStimulus(0, 8'd123, 12'h123, 8, "a123");

        // Undersized result keeps only the low decimal digits.
        applyStimulus(1, 8'd199, 12'h099, 8, "b199");
        applyStimulus(1, 8'd255, 12'h055, 8, "b255");
        applyStimulus(1, 8'd42,  12'h042, 8, "b42");

        // Single-bit operand: one CONV cycle.
        applyStimulus(2, 8'd1, 12'h001, 1, "c1");
        applyStimulus(2, 8'd0, 12'h000, 1, "c0");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard stop in case something wedges the run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
